// File: rtl/eth_sched_pkg.sv
// Shared definitions for the burst scheduler: state encodings, default widths
// and the index-width helper.
package eth_sched_pkg;

   localparam int DEF_NUM_STREAMS = 4;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_GAP_W       = 16;
   localparam int DEF_TO_W        = 24;

   typedef logic [2:0] sched_state_e;

   localparam sched_state_e ST_IDLE  = 3'd0;
   localparam sched_state_e ST_PICK  = 3'd1;
   localparam sched_state_e ST_LOAD  = 3'd2;
   localparam sched_state_e ST_RUN   = 3'd3;
   localparam sched_state_e ST_DRAIN = 3'd4;
   localparam sched_state_e ST_GAP   = 3'd5;

   // clog2 with a floor of 1 so a stream index is never zero bits wide
   function automatic int idx_width(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << w) < n) w = w + 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin picker: first set mask bit strictly after ptr,
// wrapping modulo N.
module eth_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant,
   output logic             grant_valid
);

   logic [IDX_W-1:0] idx;

   // Scan from the farthest candidate back to ptr+1 so the nearest one wins last.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IDX_W'((int'(ptr) + k) % N);
         if (mask[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_stream_sched.sv
// Burst scheduler: picks a stream round-robin, loads its profile into the
// packet generator, runs one counted burst, then waits out the inter-burst gap.
module eth_stream_sched
   import eth_sched_pkg::*;
#(
   parameter int NUM_STREAMS = DEF_NUM_STREAMS,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int GAP_W       = DEF_GAP_W,
   parameter int TO_W        = DEF_TO_W,
   parameter int IDX_W       = idx_width(NUM_STREAMS)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        io_run,
   input  logic                        io_abort,
   input  logic [NUM_STREAMS-1:0]      io_stream_en,
   input  logic [NUM_STREAMS*CNT_W-1:0] io_burst_count,
   input  logic [NUM_STREAMS*16-1:0]   io_pkt_len,
   input  logic [NUM_STREAMS*2-1:0]    io_payload_mode,
   input  logic [GAP_W-1:0]            io_burst_gap,
   input  logic [TO_W-1:0]             io_timeout,
   input  logic                        gen_send_done,
   output logic                        gen_enable,
   output logic                        gen_send_mode,
   output logic [CNT_W-1:0]            gen_send_count,
   output logic [15:0]                 gen_pkt_len,
   output logic [1:0]                  gen_payload_mode,
   output logic [IDX_W-1:0]            io_cur_stream,
   output logic                        io_busy,
   output logic                        io_timeout_err,
   output logic [31:0]                 io_burst_total
);

   sched_state_e           state;
   logic [IDX_W-1:0]       ptr;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       grant;
   logic                   grant_valid;
   logic [NUM_STREAMS-1:0] elig;
   logic [GAP_W-1:0]       gap_cnt;
   logic [TO_W-1:0]        wd_cnt;
   logic                   run_q;
   logic                   wd_hit;

   // A zero-count stream would never see send_done, so it is not eligible.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_STREAMS; i++)
         elig[i] = io_stream_en[i] && (io_burst_count[i*CNT_W +: CNT_W] != '0);
   end

   eth_rr_arbiter #(
      .N     (NUM_STREAMS),
      .IDX_W (IDX_W)
   ) u_arb (
      .mask        (elig),
      .ptr         (ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Fires on the last allowed RUN cycle, so gen_enable is high exactly io_timeout cycles.
   assign wd_hit = (io_timeout != '0) &&
                   (((TO_W+1)'(wd_cnt) + (TO_W+1)'(1)) == (TO_W+1)'(io_timeout));

   assign gen_enable    = (state == ST_RUN);
   assign gen_send_mode = (state == ST_RUN);
   assign io_busy       = (state != ST_IDLE);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state            <= ST_IDLE;
         ptr              <= IDX_W'(NUM_STREAMS - 1);
         pick_idx         <= '0;
         io_cur_stream    <= '0;
         gen_send_count   <= '0;
         gen_pkt_len      <= '0;
         gen_payload_mode <= '0;
         gap_cnt          <= '0;
         wd_cnt           <= '0;
         run_q            <= 1'b0;
         io_timeout_err   <= 1'b0;
         io_burst_total   <= '0;
      end else begin
         run_q <= io_run;
         if (io_run && !run_q)
            io_timeout_err <= 1'b0;

         if (io_abort) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (io_run) state <= ST_PICK;
               ST_PICK: begin
                  if (!io_run)
                     state <= ST_IDLE;
                  else if (grant_valid) begin
                     pick_idx <= grant;
                     state    <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  gen_send_count   <= io_burst_count[pick_idx*CNT_W +: CNT_W];
                  gen_pkt_len      <= io_pkt_len[pick_idx*16 +: 16];
                  gen_payload_mode <= io_payload_mode[pick_idx*2 +: 2];
                  io_cur_stream    <= pick_idx;
                  ptr              <= pick_idx;
                  wd_cnt           <= '0;
                  state            <= ST_RUN;
               end
               ST_RUN: begin
                  if (gen_send_done) begin
                     io_burst_total <= io_burst_total + 32'd1;
                     state          <= ST_DRAIN;
                  end else if (wd_hit) begin
                     io_timeout_err <= 1'b1;
                     state          <= ST_DRAIN;
                  end else begin
                     wd_cnt <= wd_cnt + TO_W'(1);
                  end
               end
               ST_DRAIN: begin
                  // Generator must drop send_done before the next burst can be armed.
                  if (!gen_send_done) begin
                     if (io_burst_gap == '0)
                        state <= io_run ? ST_PICK : ST_IDLE;
                     else begin
                        gap_cnt <= io_burst_gap - GAP_W'(1);
                        state   <= ST_GAP;
                     end
                  end
               end
               ST_GAP: begin
                  if (gap_cnt == '0)
                     state <= io_run ? ST_PICK : ST_IDLE;
                  else
                     gap_cnt <= gap_cnt - GAP_W'(1);
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_stream_sched.sv
// Directed bench for eth_stream_sched with a simple generator model that
// raises send_done after send_count RUN cycles.
module tb_eth_stream_sched;

   localparam int NS    = 4;
   localparam int CNT_W = 32;
   localparam int GAP_W = 16;
   localparam int TO_W  = 24;

   logic                 clock;
   logic                 reset;
   logic                 io_run;
   logic                 io_abort;
   logic [NS-1:0]        io_stream_en;
   logic [NS*CNT_W-1:0]  io_burst_count;
   logic [NS*16-1:0]     io_pkt_len;
   logic [NS*2-1:0]      io_payload_mode;
   logic [GAP_W-1:0]     io_burst_gap;
   logic [TO_W-1:0]      io_timeout;
   logic                 gen_send_done;
   logic                 gen_enable;
   logic                 gen_send_mode;
   logic [CNT_W-1:0]     gen_send_count;
   logic [15:0]          gen_pkt_len;
   logic [1:0]           gen_payload_mode;
   logic [1:0]           io_cur_stream;
   logic                 io_busy;
   logic                 io_timeout_err;
   logic [31:0]          io_burst_total;

   int checks = 0;
   int errors = 0;

   logic model_on   = 1'b0;
   logic model_done = 1'b0;
   logic force_done = 1'b0;
   int   run_cyc    = 0;

   assign gen_send_done = model_on ? model_done : force_done;

   eth_stream_sched dut (
      .clock            (clock),
      .reset            (reset),
      .io_run           (io_run),
      .io_abort         (io_abort),
      .io_stream_en     (io_stream_en),
      .io_burst_count   (io_burst_count),
      .io_pkt_len       (io_pkt_len),
      .io_payload_mode  (io_payload_mode),
      .io_burst_gap     (io_burst_gap),
      .io_timeout       (io_timeout),
      .gen_send_done    (gen_send_done),
      .gen_enable       (gen_enable),
      .gen_send_mode    (gen_send_mode),
      .gen_send_count   (gen_send_count),
      .gen_pkt_len      (gen_pkt_len),
      .gen_payload_mode (gen_payload_mode),
      .io_cur_stream    (io_cur_stream),
      .io_busy          (io_busy),
      .io_timeout_err   (io_timeout_err),
      .io_burst_total   (io_burst_total)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Generator model: one packet per RUN cycle, done held until enable drops.
   always @(negedge clock) begin
      if (gen_enable === 1'b1) begin
         run_cyc = run_cyc + 1;
         if (run_cyc >= int'(gen_send_count)) model_done = 1'b1;
      end else begin
         run_cyc    = 0;
         model_done = 1'b0;
      end
   end

   task automatic set_stream(input int i, input int cnt, input int len, input int mode);
      io_burst_count[i*CNT_W +: CNT_W] = CNT_W'(cnt);
      io_pkt_len[i*16 +: 16]           = 16'(len);
      io_payload_mode[i*2 +: 2]        = 2'(mode);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Returns at the first negedge with gen_enable high after a low stretch.
   task automatic wait_burst(output int stream, output int idle, output bit ok);
      int n;
      n = 0; idle = 0;
      while (gen_enable === 1'b1 && n < 1000) begin @(negedge clock); n++; end
      while (gen_enable !== 1'b1 && n < 1000) begin idle++; @(negedge clock); n++; end
      ok     = (gen_enable === 1'b1);
      stream = int'(io_cur_stream);
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      while (io_busy !== 1'b0 && n < 300) begin @(negedge clock); n++; end
      ok = (io_busy === 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0; io_run = 1'b0; io_abort = 1'b0; io_stream_en = '0;
      io_burst_count = '0; io_pkt_len = '0; io_payload_mode = '0;
      io_burst_gap = '0; io_timeout = '0; model_on = 1'b0; force_done = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({gen_enable, gen_send_mode, io_busy, io_timeout_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {gen_enable, gen_send_mode, io_busy, io_timeout_err});
      end
      checks++;
      if (gen_send_count !== 0 || gen_pkt_len !== 0 || gen_payload_mode !== 0) begin
         errors++; $display("FAIL reset_cfg got %0d/%0d/%0d want 0/0/0", gen_send_count, gen_pkt_len, gen_payload_mode);
      end
      checks++;
      if (io_cur_stream !== 0 || io_burst_total !== 0) begin
         errors++; $display("FAIL reset_stat got %0d/%0d want 0/0", io_cur_stream, io_burst_total);
      end
      reset = 1'b1;
   endtask

   task automatic test_round_robin();
      int s, idle; bit ok;
      apply_reset();
      model_on = 1'b1;
      io_stream_en = 4'b1111;
      for (int i = 0; i < NS; i++) set_stream(i, i + 1, 64 + i, i);
      io_burst_gap = 16'd5; io_timeout = '0;
      io_run = 1'b1;
      @(negedge clock);
      checks++;
      if (gen_enable !== 1'b0) begin errors++; $display("FAIL lat_edge1 got %b want 0", gen_enable); end
      @(negedge clock);
      checks++;
      if (gen_enable !== 1'b0) begin errors++; $display("FAIL lat_edge2 got %b want 0", gen_enable); end
      @(negedge clock);
      checks++;
      if (gen_enable !== 1'b1 || gen_send_mode !== 1'b1 || io_busy !== 1'b1) begin
         errors++; $display("FAIL lat_edge3 got en=%b mode=%b busy=%b want 1/1/1", gen_enable, gen_send_mode, io_busy);
      end
      checks++;
      if (io_cur_stream !== 0 || gen_send_count !== 1 || gen_pkt_len !== 64 || gen_payload_mode !== 0) begin
         errors++; $display("FAIL rr_load0 got s=%0d c=%0d l=%0d m=%0d want 0/1/64/0",
                            io_cur_stream, gen_send_count, gen_pkt_len, gen_payload_mode);
      end
      for (int k = 1; k <= 4; k++) begin
         wait_burst(s, idle, ok);
         if (k == 4) io_run = 1'b0;
         checks++;
         if (!ok || s != k % NS || gen_send_count !== CNT_W'(k % NS + 1) || gen_pkt_len !== 16'(64 + k % NS)) begin
            errors++; $display("FAIL rr_grant%0d got ok=%0d s=%0d c=%0d l=%0d want s=%0d c=%0d l=%0d",
                               k, ok, s, gen_send_count, gen_pkt_len, k % NS, k % NS + 1, 64 + k % NS);
         end
         checks++;
         if (idle != 8) begin errors++; $display("FAIL rr_gap%0d got %0d idle want 8", k, idle); end
      end
      wait_idle(ok);
      checks++;
      if (!ok || io_burst_total !== 32'd5 || gen_enable !== 1'b0) begin
         errors++; $display("FAIL rr_total got ok=%0d total=%0d en=%b want 1/5/0", ok, io_burst_total, gen_enable);
      end
   endtask

   task automatic test_sparse_mask();
      int s, idle; bit ok;
      int exp_s[4] = '{0, 2, 0, 2};
      apply_reset();
      model_on = 1'b1;
      io_stream_en = 4'b0101;
      for (int i = 0; i < NS; i++) set_stream(i, 2, 100, 1);
      io_burst_gap = '0;
      io_run = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_burst(s, idle, ok);
         if (k == 3) io_stream_en = 4'b0000;
         checks++;
         if (!ok || s != exp_s[k] || (k > 0 && idle != 3)) begin
            errors++; $display("FAIL sparse_grant%0d got ok=%0d s=%0d idle=%0d want s=%0d idle=3", k, ok, s, idle, exp_s[k]);
         end
      end
      repeat (10) @(negedge clock);
      checks++;
      if (gen_enable !== 1'b0 || io_busy !== 1'b1 || io_burst_total !== 32'd4) begin
         errors++; $display("FAIL sparse_hold got en=%b busy=%b total=%0d want 0/1/4", gen_enable, io_busy, io_burst_total);
      end
      io_run = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (io_busy !== 1'b0) begin errors++; $display("FAIL sparse_stop got busy=%b want 0", io_busy); end
   endtask

   task automatic test_timeout();
      int s, idle, hi, n; bit ok;
      apply_reset();
      model_on = 1'b0; force_done = 1'b0;
      io_stream_en = 4'b0001;
      set_stream(0, 5, 60, 2);
      io_burst_gap = '0; io_timeout = 24'd100;
      io_run = 1'b1;
      wait_burst(s, idle, ok);
      hi = 1; n = 0;
      while (gen_enable === 1'b1 && n < 300) begin
         @(negedge clock); n++;
         if (gen_enable === 1'b1) hi++;
      end
      io_run = 1'b0;
      checks++;
      if (!ok || hi != 100) begin errors++; $display("FAIL wd_len got ok=%0d cycles=%0d want 100", ok, hi); end
      checks++;
      if (io_timeout_err !== 1'b1 || io_burst_total !== 0) begin
         errors++; $display("FAIL wd_err got err=%b total=%0d want 1/0", io_timeout_err, io_burst_total);
      end
      wait_idle(ok);
      checks++;
      if (!ok || io_timeout_err !== 1'b1) begin
         errors++; $display("FAIL wd_sticky got ok=%0d err=%b want 1/1", ok, io_timeout_err);
      end
   endtask

   task automatic test_run_stop();
      int s, idle, hi, n; bit ok;
      model_on = 1'b1;
      io_stream_en = 4'b0001;
      set_stream(0, 2, 70, 3);
      io_timeout = '0; io_burst_gap = 16'd3;
      io_run = 1'b1;
      @(negedge clock);
      checks++;
      if (io_timeout_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", io_timeout_err); end
      wait_burst(s, idle, ok);
      io_run = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok || io_burst_total !== 32'd1 || gen_enable !== 1'b0) begin
         errors++; $display("FAIL stop_total got ok=%0d total=%0d en=%b want 1/1/0", ok, io_burst_total, gen_enable);
      end
      // done and watchdog land on the same RUN cycle
      set_stream(0, 3, 70, 3);
      io_timeout = 24'd3;
      io_run = 1'b1;
      wait_burst(s, idle, ok);
      io_run = 1'b0;
      hi = 1; n = 0;
      while (gen_enable === 1'b1 && n < 50) begin
         @(negedge clock); n++;
         if (gen_enable === 1'b1) hi++;
      end
      wait_idle(ok);
      checks++;
      if (!ok || hi != 3 || io_burst_total !== 32'd2 || io_timeout_err !== 1'b0) begin
         errors++; $display("FAIL done_vs_wd got ok=%0d cyc=%0d total=%0d err=%b want 1/3/2/0",
                            ok, hi, io_burst_total, io_timeout_err);
      end
   endtask

   task automatic test_abort();
      int s, idle; bit ok;
      apply_reset();
      model_on = 1'b0; force_done = 1'b0;
      io_stream_en = 4'b0001;
      set_stream(0, 10, 80, 1);
      io_timeout = '0; io_burst_gap = '0;
      io_run = 1'b1;
      wait_burst(s, idle, ok);
      repeat (2) @(negedge clock);
      io_abort = 1'b1;
      @(negedge clock);
      io_abort = 1'b0;
      checks++;
      if (!ok || gen_enable !== 1'b0 || io_busy !== 1'b0 || io_burst_total !== 0) begin
         errors++; $display("FAIL abort got ok=%0d en=%b busy=%b total=%0d want 1/0/0/0", ok, gen_enable, io_busy, io_burst_total);
      end
      wait_burst(s, idle, ok);
      force_done = 1'b1; io_abort = 1'b1;
      @(negedge clock);
      force_done = 1'b0; io_abort = 1'b0; io_run = 1'b0;
      checks++;
      if (!ok || gen_enable !== 1'b0 || io_busy !== 1'b0 || io_burst_total !== 0) begin
         errors++; $display("FAIL abort_done got ok=%0d en=%b busy=%b total=%0d want 1/0/0/0", ok, gen_enable, io_busy, io_burst_total);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid_run();
      int s, idle; bit ok;
      apply_reset();
      model_on = 1'b1;
      io_stream_en = 4'b1111;
      set_stream(0, 1, 90, 1);
      for (int i = 1; i < NS; i++) set_stream(i, 5, 90 + i, 2);
      io_timeout = '0; io_burst_gap = '0;
      io_run = 1'b1;
      wait_burst(s, idle, ok);
      wait_burst(s, idle, ok);
      repeat (2) @(negedge clock);
      checks++;
      if (!ok || s != 1 || io_burst_total !== 32'd1 || gen_enable !== 1'b1) begin
         errors++; $display("FAIL pre_reset got ok=%0d s=%0d total=%0d en=%b want 1/1/1/1", ok, s, io_burst_total, gen_enable);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({gen_enable, gen_send_mode, io_busy, io_timeout_err} !== 4'b0000 || gen_send_count !== 0 ||
          gen_pkt_len !== 0 || gen_payload_mode !== 0 || io_cur_stream !== 0 || io_burst_total !== 0) begin
         errors++; $display("FAIL mid_reset got en=%b c=%0d l=%0d m=%0d s=%0d total=%0d want all 0",
                            gen_enable, gen_send_count, gen_pkt_len, gen_payload_mode, io_cur_stream, io_burst_total);
      end
      set_stream(1, 0, 91, 2);
      reset = 1'b1;
      wait_burst(s, idle, ok);
      checks++;
      if (!ok || s != 0) begin errors++; $display("FAIL first_grant got ok=%0d s=%0d want 0", ok, s); end
      wait_burst(s, idle, ok);
      io_run = 1'b0;
      checks++;
      if (!ok || s != 2 || gen_send_count !== 5) begin
         errors++; $display("FAIL zero_skip got ok=%0d s=%0d c=%0d want 2/5", ok, s, gen_send_count);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL final_idle got busy=%b want 0", io_busy); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_sparse_mask();
      test_timeout();
      test_run_stop();
      test_abort();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
